// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the integer register-file writeback controller.
// Requester indices are fixed so each execution unit always lands on the same port.
package regfile_wb_ctrl_pkg;

    localparam int WB_ALU  = 0;
    localparam int WB_LSU  = 1;
    localparam int WB_MDU  = 2;
    localparam int WB_NSRC = 3;

    // Index width that stays legal (>=1 bit) even for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester scanning from ptr upwards.
// Purely combinational; no backpressure of its own, the owner decides when ptr advances.
module rr_arbiter
    import regfile_wb_ctrl_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Walk from the farthest candidate back to ptr so the nearest valid one wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            pos = sum[IW-1:0];
            if (valid[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: round-robin write-port arbitration plus busy scoreboard.
// One-cycle latency handshake->enable; one write per cycle, losers stall with req_ready low.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    parameter  int NREQ  = WB_NSRC,
    localparam int ADDR  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ADDR-1:0]   req_reg,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic                   enable,
    output logic [ADDR-1:0]        wreg,
    output logic [WIDTH-1:0]       wdata,
    input  logic                   claim_valid,
    input  logic [ADDR-1:0]        claim_reg,
    output logic                   claim_ready,
    output logic [DEPTH-1:0]       busy
);

    localparam int PW = idx_width(NREQ);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             hs;
    logic [ADDR-1:0]  sel_reg;
    logic [WIDTH-1:0] sel_data;
    logic [DEPTH-1:0] busy_set;
    logic [DEPTH-1:0] busy_clr;

    rr_arbiter #(
        .N     (NREQ)
    ) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign req_ready = reset ? '0 : gnt;
    assign hs        = gnt_any & ~reset;
    assign ptr_nxt   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Grant is one-hot, so an AND-OR mux picks the winner's register and data.
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_reg  = sel_reg  | req_reg[i*ADDR +: ADDR];
                sel_data = sel_data | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr    <= '0;
            enable <= 1'b0;
            wreg   <= '0;
            wdata  <= '0;
        end else if (hs) begin
            ptr    <= ptr_nxt;
            enable <= (sel_reg != '0);
            wreg   <= sel_reg;
            wdata  <= sel_data;
        end else begin
            enable <= 1'b0;
        end
    end

    // x0 is never tracked: its claim is accepted without reserving anything.
    assign claim_ready = claim_valid & ~busy[claim_reg] & ~reset;
    assign busy_set    = (claim_ready && claim_reg != '0) ? (DEPTH'(1) << claim_reg) : '0;
    // Clearing on the commit edge means a reader seeing the bit drop also sees the new value.
    assign busy_clr    = enable ? (DEPTH'(1) << wreg) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed plus randomized bench for regfile_wb_ctrl against an arithmetic reference model.
module tb_regfile_wb_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREQ  = 3;
    localparam int ADDR  = 5;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ADDR-1:0]  req_reg;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  enable;
    logic [ADDR-1:0]       wreg;
    logic [WIDTH-1:0]      wdata;
    logic                  claim_valid;
    logic [ADDR-1:0]       claim_reg;
    logic                  claim_ready;
    logic [DEPTH-1:0]      busy;

    regfile_wb_ctrl #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .NREQ        (NREQ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .enable      (enable),
        .wreg        (wreg),
        .wdata       (wdata),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .claim_ready (claim_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int               m_ptr;
    logic [DEPTH-1:0] m_busy;
    logic             m_en;
    logic [ADDR-1:0]  m_wreg;
    logic [WIDTH-1:0] m_wdata;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ*ADDR-1:0] pr3(input logic [ADDR-1:0] a, input logic [ADDR-1:0] b,
                                                 input logic [ADDR-1:0] c);
        return {c, b, a};
    endfunction

    function automatic logic [NREQ*WIDTH-1:0] pd3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] c);
        return {c, b, a};
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_busy  = '0;
        m_en    = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
    endtask

    // One clock cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*ADDR-1:0] r,
                        input logic [NREQ*WIDTH-1:0] d, input logic cv, input logic [ADDR-1:0] cr,
                        output logic [NREQ-1:0] rdy_o, output logic crdy_o, output int g);
        logic [NREQ-1:0] exp_rdy;
        logic            exp_c;
        logic [ADDR-1:0] regv;
        int              j;
        chk(64'(enable), 64'(m_en),    "enable");
        chk(64'(wreg),   64'(m_wreg),  "wreg");
        chk(64'(wdata),  64'(m_wdata), "wdata");
        chk(64'(busy),   64'(m_busy),  "busy");
        req_valid   = v;
        req_reg     = r;
        req_data    = d;
        claim_valid = cv;
        claim_reg   = cr;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g < 0 && v[j]) g = j;
        end
        exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
        exp_c   = cv && !m_busy[cr];
        chk(64'(req_ready),   64'(exp_rdy), "req_ready");
        chk(64'(claim_ready), 64'(exp_c),   "claim_ready");
        rdy_o  = req_ready;
        crdy_o = claim_ready;
        if (m_en) m_busy[m_wreg] = 1'b0;
        if (exp_c && cr != '0) m_busy[cr] = 1'b1;
        if (g >= 0) begin
            regv    = r[g*ADDR +: ADDR];
            m_wreg  = regv;
            m_wdata = d[g*WIDTH +: WIDTH];
            m_en    = (regv != '0);
            m_ptr   = (g + 1) % NREQ;
        end else begin
            m_en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [NREQ-1:0]  rdy;
    logic             crdy;
    int               g;
    logic [NREQ-1:0]  pv;
    logic [ADDR-1:0]  prg [NREQ];
    logic [WIDTH-1:0] pdt [NREQ];
    logic [NREQ*ADDR-1:0]  rv;
    logic [NREQ*WIDTH-1:0] dv;

    initial begin
        reset       = 1'b1;
        req_valid   = '1;
        req_reg     = '0;
        req_data    = '0;
        claim_valid = 1'b1;
        claim_reg   = 5'd3;
        model_reset();
        @(posedge clk);
        #1;
        chk(64'(enable),      64'd0, "rst_enable");
        chk(64'(wreg),        64'd0, "rst_wreg");
        chk(64'(wdata),       64'd0, "rst_wdata");
        chk(64'(busy),        64'd0, "rst_busy");
        chk(64'(req_ready),   64'd0, "rst_req_ready");
        chk(64'(claim_ready), 64'd0, "rst_claim_ready");
        req_valid   = '0;
        claim_valid = 1'b0;
        reset       = 1'b0;

        // Three simultaneous requesters from ptr=0
        step(3'b111, pr3(5'd1, 5'd2, 5'd3), pd3(32'h11, 32'h22, 32'h33), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b001, "rr_grant0");
        chk(64'(enable), 64'd1, "rr_en0");
        chk(64'(wreg), 64'd1, "rr_wreg0");
        step(3'b110, pr3(5'd1, 5'd2, 5'd3), pd3(32'h11, 32'h22, 32'h33), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b010, "rr_grant1");
        chk(64'(wreg), 64'd2, "rr_wreg1");
        chk(64'(wdata), 64'h22, "rr_wdata1");
        step(3'b100, pr3(5'd1, 5'd2, 5'd3), pd3(32'h11, 32'h22, 32'h33), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b100, "rr_grant2");
        chk(64'(enable), 64'd1, "rr_en2");
        chk(64'(wreg), 64'd3, "rr_wreg2");
        step(3'b000, '0, '0, 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(enable), 64'd0, "rr_idle_en");

        // Claim r5, refused re-claim, writeback clears it
        step(3'b000, '0, '0, 1'b1, 5'd5, rdy, crdy, g);
        chk(64'(crdy), 64'd1, "claim5_acc");
        chk(64'(busy[5]), 64'd1, "claim5_busy");
        step(3'b000, '0, '0, 1'b1, 5'd5, rdy, crdy, g);
        chk(64'(crdy), 64'd0, "claim5_refused");
        step(3'b010, pr3(5'd0, 5'd5, 5'd0), pd3(32'h0, 32'hDEADBEEF, 32'h0), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b010, "wb5_grant");
        chk(64'(enable), 64'd1, "wb5_en");
        chk(64'(wreg), 64'd5, "wb5_wreg");
        chk(64'(wdata), 64'hDEADBEEF, "wb5_wdata");
        chk(64'(busy[5]), 64'd1, "wb5_busy_held");
        step(3'b000, '0, '0, 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(busy[5]), 64'd0, "wb5_busy_clr");

        // Write to x0: handshake without enable
        step(3'b001, pr3(5'd0, 5'd0, 5'd0), pd3(32'hFFFFFFFF, 32'h0, 32'h0), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b001, "x0_grant");
        chk(64'(enable), 64'd0, "x0_no_en");
        chk(64'(wreg), 64'd0, "x0_wreg");

        // Requester 2 alone for four cycles
        for (int i = 0; i < 4; i++) begin
            step(3'b100, pr3(5'd0, 5'd0, 5'(10 + i)), pd3(32'h0, 32'h0, 32'(i)), 1'b0, 5'd0, rdy, crdy, g);
            chk(64'(rdy), 64'b100, "solo2_grant");
            chk(64'(enable), 64'd1, "solo2_en");
        end
        step(3'b011, pr3(5'd4, 5'd6, 5'd0), pd3(32'h44, 32'h66, 32'h0), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b001, "after_solo_grant0");
        step(3'b010, pr3(5'd4, 5'd6, 5'd0), pd3(32'h44, 32'h66, 32'h0), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b010, "after_solo_grant1");

        // Reset mid-operation
        step(3'b000, '0, '0, 1'b1, 5'd7, rdy, crdy, g);
        step(3'b000, '0, '0, 1'b1, 5'd8, rdy, crdy, g);
        step(3'b001, pr3(5'd9, 5'd0, 5'd0), pd3(32'h99, 32'h0, 32'h0), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(enable), 64'd1, "inflight_en");
        chk(64'(busy), 64'h180, "inflight_busy");
        req_valid   = 3'b010;
        req_reg     = pr3(5'd0, 5'd12, 5'd0);
        req_data    = pd3(32'h0, 32'h1212, 32'h0);
        claim_valid = 1'b1;
        claim_reg   = 5'd9;
        reset       = 1'b1;
        #1;
        chk(64'(enable),      64'd0, "arst_enable");
        chk(64'(wreg),        64'd0, "arst_wreg");
        chk(64'(busy),        64'd0, "arst_busy");
        chk(64'(req_ready),   64'd0, "arst_req_ready");
        chk(64'(claim_ready), 64'd0, "arst_claim_ready");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(3'b010, pr3(5'd0, 5'd12, 5'd0), pd3(32'h0, 32'h1212, 32'h0), 1'b0, 5'd0, rdy, crdy, g);
        chk(64'(rdy), 64'b010, "post_rst_grant");
        chk(64'(wreg), 64'd12, "post_rst_wreg");

        // Randomized traffic; pending requests are held stable until granted
        pv = '0;
        for (int i = 0; i < NREQ; i++) begin
            prg[i] = '0;
            pdt[i] = '0;
        end
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    pv[i]  = ($urandom_range(0, 3) != 0);
                    prg[i] = 5'($urandom_range(0, 15));
                    pdt[i] = $urandom;
                end
            end
            rv = pr3(prg[0], prg[1], prg[2]);
            dv = pd3(pdt[0], pdt[1], pdt[2]);
            step(pv, rv, dv, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), rdy, crdy, g);
            if (g >= 0) pv[g] = 1'b0;
        end
        step(3'b000, '0, '0, 1'b0, 5'd0, rdy, crdy, g);
        step(3'b000, '0, '0, 1'b0, 5'd0, rdy, crdy, g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
